// File: rtl/pipe_stage_skid_if.sv
// Valid/ready handshake bundle carrying one packed payload between pipeline stages.
// The producer side uses the master modport, the consumer side the slave modport.
interface pipe_stage_skid_if #(
  parameter int WIDTH = 32
) ();
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_skid.sv
// Generic inter-stage pipeline register with optional 2-entry skid buffer.
// With SKID=1 the upstream ready is registered so backpressure never forms a
// combinational path across stages; with SKID=0 a single entry is used and
// ready is derived combinationally from the downstream side.
// Also provides a synchronous flush and a saturating stall-cycle counter.
module pipe_stage_skid #(
  parameter int               WIDTH     = 32,
  parameter int               SKID      = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               CNT_W     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     cnt_clr,
  pipe_stage_skid_if.slave         in_if,
  pipe_stage_skid_if.master        out_if,
  output logic [1:0]               occupancy,
  output logic [CNT_W-1:0]         stall_cnt
);

  localparam bit HAS_SKID = (SKID != 0);

  // State value doubles as the number of entries held.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             rdy_q;
  logic             head_valid;
  logic             in_ready;
  logic             accept;
  logic             drain;

  assign head_valid = (state_q != EMPTY);
  assign accept     = in_if.valid & in_ready;
  assign drain      = head_valid & out_if.ready;

  // State and payload registers; reset and flush both restore RESET_VAL payloads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      head_q  <= RESET_VAL;
      skid_q  <= RESET_VAL;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
      rdy_q   <= (state_d != TWO);
    end
  end

  // Next-state and payload steering; flush wins over any accept or drain.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      head_d  = RESET_VAL;
      skid_d  = RESET_VAL;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = ONE;
            head_d  = in_if.data;
          end
        end
        ONE: begin
          if (accept && drain) begin
            head_d = in_if.data;
          end else if (accept && HAS_SKID) begin
            state_d = TWO;
            skid_d  = in_if.data;
          end else if (drain) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (drain) begin
            state_d = ONE;
            head_d  = skid_q;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  // Outputs: head entry, occupancy and upstream ready (registered when skid is present).
  always_comb begin
    out_if.valid = head_valid;
    out_if.data  = head_q;
    occupancy    = state_q;
    if (HAS_SKID) begin
      in_ready = rdy_q;
    end else begin
      in_ready = rdy_q & (!head_valid | out_if.ready);
    end
    in_if.ready = in_ready;
  end

  // Saturating count of stalled cycles; clear beats increment, flush leaves it alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
    end else if (head_valid && !out_if.ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed testbench for pipe_stage_skid: one skid instance (SKID=1, CNT_W=4)
// and one single-entry instance (SKID=0, CNT_W=16), each task checks its own scenario.
module tb_pipe_stage_skid;

  logic       clk;
  logic       rst;
  logic       flush_a, cnt_clr_a;
  logic       flush_b, cnt_clr_b;
  logic [1:0] occ_a, occ_b;
  logic [3:0] cnt_a;
  logic [15:0] cnt_b;

  int checks;
  int passes;

  pipe_stage_skid_if #(.WIDTH(8)) ia ();
  pipe_stage_skid_if #(.WIDTH(8)) oa ();
  pipe_stage_skid_if #(.WIDTH(8)) ib ();
  pipe_stage_skid_if #(.WIDTH(8)) ob ();

  pipe_stage_skid #(.WIDTH(8), .SKID(1), .RESET_VAL(8'hEE), .CNT_W(4)) dut_a (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush_a),
    .cnt_clr   (cnt_clr_a),
    .in_if     (ia),
    .out_if    (oa),
    .occupancy (occ_a),
    .stall_cnt (cnt_a)
  );

  pipe_stage_skid #(.WIDTH(8), .SKID(0), .RESET_VAL(8'hC3), .CNT_W(16)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush_b),
    .cnt_clr   (cnt_clr_b),
    .in_if     (ib),
    .out_if    (ob),
    .occupancy (occ_b),
    .stall_cnt (cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Continuous properties: occupancy bound on both instances, head stable while stalled.
  logic       stall_a_prev, stall_b_prev;
  logic [7:0] data_a_prev, data_b_prev;
  initial begin
    stall_a_prev = 1'b0;
    stall_b_prev = 1'b0;
    data_a_prev  = 8'h00;
    data_b_prev  = 8'h00;
  end
  always @(negedge clk) begin
    if (!rst) begin
      checks++; if (occ_a > 2'd2) $display("[TB] FAIL occ_bound_a: got %0d want <=2", occ_a); else passes++;
      checks++; if (occ_b > 2'd1) $display("[TB] FAIL occ_bound_b: got %0d want <=1", occ_b); else passes++;
      if (stall_a_prev) begin
        checks++;
        if (oa.valid !== 1'b1 || oa.data !== data_a_prev)
          $display("[TB] FAIL stable_a: got v=%0b d=%h want v=1 d=%h", oa.valid, oa.data, data_a_prev);
        else passes++;
      end
      if (stall_b_prev) begin
        checks++;
        if (ob.valid !== 1'b1 || ob.data !== data_b_prev)
          $display("[TB] FAIL stable_b: got v=%0b d=%h want v=1 d=%h", ob.valid, ob.data, data_b_prev);
        else passes++;
      end
    end
    stall_a_prev <= !rst && !flush_a && (oa.valid === 1'b1) && (oa.ready === 1'b0);
    stall_b_prev <= !rst && !flush_b && (ob.valid === 1'b1) && (ob.ready === 1'b0);
    data_a_prev  <= oa.data;
    data_b_prev  <= ob.data;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++; if (ia.ready !== 1'b0) $display("[TB] FAIL rst_ready_a: got %0b want 0", ia.ready); else passes++;
    checks++; if (oa.valid !== 1'b0) $display("[TB] FAIL rst_valid_a: got %0b want 0", oa.valid); else passes++;
    checks++; if (oa.data !== 8'hEE) $display("[TB] FAIL rst_data_a: got %h want ee", oa.data); else passes++;
    checks++; if (ob.data !== 8'hC3) $display("[TB] FAIL rst_data_b: got %h want c3", ob.data); else passes++;
    checks++; if (ib.ready !== 1'b0) $display("[TB] FAIL rst_ready_b: got %0b want 0", ib.ready); else passes++;
    step();
    step();
    rst = 1'b0;
    step();
    checks++; if (ia.ready !== 1'b1) $display("[TB] FAIL rel_ready_a: got %0b want 1", ia.ready); else passes++;
    checks++; if (ib.ready !== 1'b1) $display("[TB] FAIL rel_ready_b: got %0b want 1", ib.ready); else passes++;
    // Fill to two entries, then reset mid-transfer.
    oa.ready = 1'b0;
    ia.valid = 1'b1; ia.data = 8'h11;
    step();
    ia.data = 8'h22;
    step();
    ia.valid = 1'b0;
    checks++; if (occ_a !== 2'd2) $display("[TB] FAIL fill_occ_a: got %0d want 2", occ_a); else passes++;
    checks++; if (cnt_a !== 4'd1) $display("[TB] FAIL fill_cnt_a: got %0d want 1", cnt_a); else passes++;
    rst = 1'b1;
    #1;
    checks++; if (oa.valid !== 1'b0) $display("[TB] FAIL mid_rst_valid: got %0b want 0", oa.valid); else passes++;
    checks++; if (oa.data !== 8'hEE) $display("[TB] FAIL mid_rst_data: got %h want ee", oa.data); else passes++;
    checks++; if (occ_a !== 2'd0) $display("[TB] FAIL mid_rst_occ: got %0d want 0", occ_a); else passes++;
    checks++; if (cnt_a !== 4'd0) $display("[TB] FAIL mid_rst_cnt: got %0d want 0", cnt_a); else passes++;
    checks++; if (ia.ready !== 1'b0) $display("[TB] FAIL mid_rst_ready: got %0b want 0", ia.ready); else passes++;
    step();
    rst = 1'b0;
    step();
    checks++; if (ia.ready !== 1'b1) $display("[TB] FAIL rel2_ready_a: got %0b want 1", ia.ready); else passes++;
  endtask

  task automatic test_streaming();
    oa.ready = 1'b1;
    ia.valid = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      ia.data = 8'(i);
      #1;
      checks++; if (ia.ready !== 1'b1) $display("[TB] FAIL stream_ready_%0d: got %0b want 1", i, ia.ready); else passes++;
      step();
      checks++;
      if (oa.valid !== 1'b1 || oa.data !== 8'(i))
        $display("[TB] FAIL stream_out_%0d: got v=%0b d=%h want v=1 d=%h", i, oa.valid, oa.data, 8'(i));
      else passes++;
    end
    ia.valid = 1'b0;
    step();
    checks++; if (oa.valid !== 1'b0) $display("[TB] FAIL stream_empty: got %0b want 0", oa.valid); else passes++;
    checks++; if (cnt_a !== 4'd0) $display("[TB] FAIL stream_cnt: got %0d want 0", cnt_a); else passes++;
  endtask

  task automatic test_backpressure();
    oa.ready = 1'b0;
    ia.valid = 1'b1; ia.data = 8'h0A;
    #1;
    checks++; if (ia.ready !== 1'b1) $display("[TB] FAIL bp_ready_a: got %0b want 1", ia.ready); else passes++;
    step();
    ia.data = 8'h0B;
    #1;
    checks++; if (ia.ready !== 1'b1) $display("[TB] FAIL bp_ready_b: got %0b want 1", ia.ready); else passes++;
    step();
    ia.data = 8'h0C;
    checks++; if (ia.ready !== 1'b0) $display("[TB] FAIL bp_ready_drop: got %0b want 0", ia.ready); else passes++;
    checks++; if (occ_a !== 2'd2) $display("[TB] FAIL bp_occ2: got %0d want 2", occ_a); else passes++;
    step();
    step();
    checks++; if (ia.ready !== 1'b0) $display("[TB] FAIL bp_ready_held: got %0b want 0", ia.ready); else passes++;
    checks++; if (oa.data !== 8'h0A) $display("[TB] FAIL bp_head_a: got %h want 0a", oa.data); else passes++;
    oa.ready = 1'b1;
    step();
    checks++; if (oa.data !== 8'h0B) $display("[TB] FAIL bp_head_b: got %h want 0b", oa.data); else passes++;
    checks++; if (ia.ready !== 1'b1) $display("[TB] FAIL bp_ready_back: got %0b want 1", ia.ready); else passes++;
    step();
    checks++;
    if (oa.valid !== 1'b1 || oa.data !== 8'h0C)
      $display("[TB] FAIL bp_head_c: got v=%0b d=%h want v=1 d=0c", oa.valid, oa.data);
    else passes++;
    ia.valid = 1'b0;
    step();
    checks++; if (oa.valid !== 1'b0) $display("[TB] FAIL bp_empty: got %0b want 0", oa.valid); else passes++;
    checks++; if (cnt_a !== 4'd3) $display("[TB] FAIL bp_stall_cnt: got %0d want 3", cnt_a); else passes++;
  endtask

  task automatic test_flush();
    oa.ready = 1'b0;
    ia.valid = 1'b1; ia.data = 8'h31;
    step();
    ia.data = 8'h32;
    step();
    ia.data = 8'h0D;
    flush_a = 1'b1;
    step();
    flush_a = 1'b0;
    ia.valid = 1'b0;
    checks++; if (oa.valid !== 1'b0) $display("[TB] FAIL flush2_valid: got %0b want 0", oa.valid); else passes++;
    checks++; if (occ_a !== 2'd0) $display("[TB] FAIL flush2_occ: got %0d want 0", occ_a); else passes++;
    checks++; if (oa.data !== 8'hEE) $display("[TB] FAIL flush2_data: got %h want ee", oa.data); else passes++;
    checks++; if (ia.ready !== 1'b1) $display("[TB] FAIL flush2_ready: got %0b want 1", ia.ready); else passes++;
    checks++; if (cnt_a !== 4'd5) $display("[TB] FAIL flush2_cnt: got %0d want 5", cnt_a); else passes++;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (oa.valid !== 1'b0 || oa.data === 8'h0D)
        $display("[TB] FAIL flush2_quiet_%0d: got v=%0b d=%h want v=0", i, oa.valid, oa.data);
      else passes++;
    end
    // Flush with one entry while an accept is possible: the accept must be dropped.
    ia.valid = 1'b1; ia.data = 8'h41;
    step();
    ia.data = 8'h0D;
    #1;
    checks++; if (ia.ready !== 1'b1) $display("[TB] FAIL flush1_pre_ready: got %0b want 1", ia.ready); else passes++;
    flush_a = 1'b1;
    step();
    flush_a = 1'b0;
    ia.valid = 1'b0;
    checks++; if (oa.valid !== 1'b0) $display("[TB] FAIL flush1_valid: got %0b want 0", oa.valid); else passes++;
    checks++; if (occ_a !== 2'd0) $display("[TB] FAIL flush1_occ: got %0d want 0", occ_a); else passes++;
    checks++; if (cnt_a !== 4'd6) $display("[TB] FAIL flush1_cnt: got %0d want 6", cnt_a); else passes++;
    step();
    checks++; if (oa.valid !== 1'b0) $display("[TB] FAIL flush1_after: got %0b want 0", oa.valid); else passes++;
  endtask

  task automatic test_saturation();
    cnt_clr_a = 1'b1;
    step();
    cnt_clr_a = 1'b0;
    checks++; if (cnt_a !== 4'd0) $display("[TB] FAIL sat_clr0: got %0d want 0", cnt_a); else passes++;
    oa.ready = 1'b0;
    ia.valid = 1'b1; ia.data = 8'h55;
    step();
    ia.valid = 1'b0;
    for (int i = 0; i < 14; i++) step();
    checks++; if (cnt_a !== 4'd14) $display("[TB] FAIL sat_14: got %0d want 14", cnt_a); else passes++;
    for (int i = 0; i < 6; i++) step();
    checks++; if (cnt_a !== 4'd15) $display("[TB] FAIL sat_hold: got %0d want 15", cnt_a); else passes++;
    cnt_clr_a = 1'b1;
    step();
    cnt_clr_a = 1'b0;
    checks++; if (cnt_a !== 4'd0) $display("[TB] FAIL sat_clr_prio: got %0d want 0", cnt_a); else passes++;
    step();
    checks++; if (cnt_a !== 4'd1) $display("[TB] FAIL sat_resume: got %0d want 1", cnt_a); else passes++;
    checks++; if (oa.data !== 8'h55) $display("[TB] FAIL sat_head: got %h want 55", oa.data); else passes++;
    oa.ready = 1'b1;
    step();
    checks++; if (oa.valid !== 1'b0) $display("[TB] FAIL sat_drain: got %0b want 0", oa.valid); else passes++;
  endtask

  task automatic test_skid0_replace();
    ob.ready = 1'b0;
    ib.valid = 1'b1; ib.data = 8'h77;
    #1;
    checks++; if (ib.ready !== 1'b1) $display("[TB] FAIL s0_ready_empty: got %0b want 1", ib.ready); else passes++;
    step();
    ib.data = 8'h05;
    #1;
    checks++; if (ib.ready !== 1'b0) $display("[TB] FAIL s0_ready_stall: got %0b want 0", ib.ready); else passes++;
    checks++; if (ob.data !== 8'h77) $display("[TB] FAIL s0_head_77: got %h want 77", ob.data); else passes++;
    step();
    checks++; if (ob.data !== 8'h77) $display("[TB] FAIL s0_head_hold: got %h want 77", ob.data); else passes++;
    checks++; if (cnt_b !== 16'd1) $display("[TB] FAIL s0_cnt: got %0d want 1", cnt_b); else passes++;
    ob.ready = 1'b1;
    #1;
    checks++; if (ib.ready !== 1'b1) $display("[TB] FAIL s0_ready_comb: got %0b want 1", ib.ready); else passes++;
    step();
    checks++;
    if (ob.valid !== 1'b1 || ob.data !== 8'h05)
      $display("[TB] FAIL s0_replace: got v=%0b d=%h want v=1 d=05", ob.valid, ob.data);
    else passes++;
    checks++; if (occ_b !== 2'd1) $display("[TB] FAIL s0_occ: got %0d want 1", occ_b); else passes++;
    ib.valid = 1'b0;
    step();
    checks++; if (occ_b !== 2'd0) $display("[TB] FAIL s0_empty: got %0d want 0", occ_b); else passes++;
  endtask

  initial begin
    checks    = 0;
    passes    = 0;
    rst       = 1'b1;
    flush_a   = 1'b0; cnt_clr_a = 1'b0;
    flush_b   = 1'b0; cnt_clr_b = 1'b0;
    ia.valid  = 1'b0; ia.data = 8'h00; oa.ready = 1'b0;
    ib.valid  = 1'b0; ib.data = 8'h00; ob.ready = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_saturation();
    test_skid0_replace();
    step();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
